pipe_hazard_ctrl: RTL

- Sequencing controller for the 3-stage core: s1 fetch, s2 decode/execute, s3 memory/writeback.
- Tracks the destination registers of the instructions in s3 and the retired slot, using shadow state it keeps itself.
- Drives operand-forwarding selects into the s2 ALU input muxes, the load-use stall, taken-branch/jump flush and the post-reset boot bubble.
- Sits beside the s2 decode controller and owns every pipeline-register enable and bubble control.

---
 rtl/pipe_hazard_ctrl.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 3-stage core: forwarding selects, load-use stall,
// redirect flush and boot bubbles. Optional perf counters under `PIPE_PERF_CNT_EN.
module pipe_hazard_ctrl #(
    parameter logic [31:0] NOP_INSTR   = 32'h0000_0013,
    parameter int unsigned BOOT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr_s2,
    input  logic        br_taken,
    output logic        stall,
    output logic        s2_bubble,
    output logic        s3_bubble,
    output logic        pc_sel,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcJalr   = 7'b1100111;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcAriI   = 7'b0010011;
    localparam logic [6:0] OpcAriR   = 7'b0110011;
    localparam logic [6:0] OpcCsr    = 7'b1110011;

    localparam logic [1:0] BootLast  = 2'(BOOT_CYCLES - 1);

    typedef enum logic [1:0] {StBoot, StRun, StStall} state_e;

    state_e     state_q;
    logic [1:0] boot_cnt_q;

    logic       s3_valid_q, s3_we_q, s3_load_q;
    logic [4:0] s3_rd_q;
    logic       ret_valid_q, ret_we_q;
    logic [4:0] ret_rd_q;

    logic [6:0] opc;
    logic [4:0] rd, rs1, rs2;
    logic       writes_rd, uses_rs1, uses_rs2, is_load, redirect, load_use;

    always_comb begin
        opc = instr_s2[6:0];
        rd  = instr_s2[11:7];
        rs1 = instr_s2[19:15];
        rs2 = instr_s2[24:20];

        writes_rd = 1'b0;
        case (opc)
            OpcLui, OpcAuipc, OpcJal, OpcJalr, OpcLoad, OpcAriR, OpcAriI: writes_rd = 1'b1;
            default: writes_rd = 1'b0;
        endcase
        writes_rd = writes_rd && (rd != 5'd0) && (instr_s2 != NOP_INSTR);

        uses_rs1 = 1'b0;
        case (opc)
            OpcAriR, OpcAriI, OpcLoad, OpcStore, OpcBranch, OpcJalr: uses_rs1 = 1'b1;
            OpcCsr: uses_rs1 = ~instr_s2[14];
            default: uses_rs1 = 1'b0;
        endcase

        uses_rs2 = (opc == OpcAriR) || (opc == OpcStore) || (opc == OpcBranch);
        is_load  = (opc == OpcLoad);
        redirect = (opc == OpcJal) || (opc == OpcJalr) || ((opc == OpcBranch) && br_taken);

        // s3_we_q already implies rd != 0, so rs == 0 never matches
        load_use = s3_valid_q && s3_load_q && s3_we_q &&
                   ((uses_rs1 && (rs1 == s3_rd_q)) || (uses_rs2 && (rs2 == s3_rd_q)));
    end

    function automatic logic [1:0] fwd_sel(
        input logic       used,
        input logic [4:0] rs,
        input logic       s3_v,
        input logic       s3_we,
        input logic       s3_ld,
        input logic [4:0] s3_rd,
        input logic       ret_v,
        input logic       ret_we,
        input logic [4:0] ret_rd
    );
        if (!used || rs == 5'd0)                          return 2'd0;
        else if (s3_v && s3_we && !s3_ld && s3_rd == rs)  return 2'd1;
        else if (ret_v && ret_we && ret_rd == rs)         return 2'd2;
        else                                              return 2'd0;
    endfunction

    always_comb begin
        stall     = 1'b0;
        s2_bubble = 1'b0;
        s3_bubble = 1'b0;
        pc_sel    = 1'b0;
        fwd_a     = 2'd0;
        fwd_b     = 2'd0;
        case (state_q)
            StBoot: begin
                s2_bubble = 1'b1;
                s3_bubble = 1'b1;
            end
            default: begin
                fwd_a = fwd_sel(uses_rs1, rs1, s3_valid_q, s3_we_q, s3_load_q, s3_rd_q,
                                ret_valid_q, ret_we_q, ret_rd_q);
                fwd_b = fwd_sel(uses_rs2, rs2, s3_valid_q, s3_we_q, s3_load_q, s3_rd_q,
                                ret_valid_q, ret_we_q, ret_rd_q);
                // Stall beats redirect: branch operands are stale until the load retires
                if (state_q == StRun && load_use) begin
                    stall     = 1'b1;
                    s3_bubble = 1'b1;
                end else if (redirect) begin
                    pc_sel    = 1'b1;
                    s2_bubble = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StBoot;
            boot_cnt_q  <= 2'd0;
            s3_valid_q  <= 1'b0;
            s3_we_q     <= 1'b0;
            s3_load_q   <= 1'b0;
            s3_rd_q     <= 5'd0;
            ret_valid_q <= 1'b0;
            ret_we_q    <= 1'b0;
            ret_rd_q    <= 5'd0;
        end else begin
            s3_valid_q  <= ~s3_bubble;
            s3_we_q     <= writes_rd;
            s3_load_q   <= is_load;
            s3_rd_q     <= rd;
            ret_valid_q <= s3_valid_q;
            ret_we_q    <= s3_we_q;
            ret_rd_q    <= s3_rd_q;
            case (state_q)
                StBoot: begin
                    if (boot_cnt_q == BootLast) state_q <= StRun;
                    else                        boot_cnt_q <= boot_cnt_q + 2'd1;
                end
                StRun:   if (load_use) state_q <= StStall;
                default: state_q <= StRun;
            endcase
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            if (stall)  stall_cnt_q <= stall_cnt_q + 32'd1;
            if (pc_sel) flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = 32'd0;
    assign flush_cnt = 32'd0;
`endif

endmodule
